// File: rtl/alu_seq_ctrl.sv
// Execute-stage sequencer: hands arithmetic/logic ops to the external ALU,
// runs the shift ops bit-serially, and owns the SZCV flags and halt state.
module alu_seq_ctrl #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              busy,
  output logic              done,
  output logic              we,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        szcv,
  output logic              halted,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_szcv
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_CMP  = 4'b0101;
  localparam logic [3:0] OP_MOV  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SLR  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          op_lat;
  logic [DATA_W-1:0]   a_lat;
  logic [DATA_W-1:0]   b_lat;
  logic [DATA_W-1:0]   work;
  logic [SHAMT_W-1:0]  cnt;
  logic                cout;
  logic                accept;
  logic                shift_run;
  logic [DATA_W:0]     step;
  logic                done_nxt;
  logic                we_nxt;
  logic [DATA_W-1:0]   result_nxt;
  logic [3:0]          szcv_nxt;
  logic                halted_nxt;

  // One-bit shift step; returns {bit shifted out, shifted word}.
  function automatic logic [DATA_W:0] shift_step(input logic [3:0] sop,
                                                 input logic [DATA_W-1:0] w);
    logic [DATA_W:0] r;
    case (sop)
      OP_SLL:  r = {w[DATA_W-1], w[DATA_W-2:0], 1'b0};
      OP_SLR:  r = {1'b0, w[DATA_W-2:0], w[DATA_W-1]};
      OP_SRL:  r = {w[0], 1'b0, w[DATA_W-1:1]};
      OP_SRA:  r = {w[0], w[DATA_W-1], w[DATA_W-1:1]};
      default: r = {1'b0, w};
    endcase
    shift_step = r;
  endfunction

  function automatic logic is_shift(input logic [3:0] o);
    is_shift = (o[3:2] == 2'b10);
  endfunction

  assign accept    = (state == IDLE) && start && !halted;
  assign shift_run = (state == SHIFT) && (cnt != {SHAMT_W{1'b0}});
  assign step      = shift_step(op_lat, work);

  assign busy   = (state != IDLE);
  assign alu_a  = a_lat;
  assign alu_b  = b_lat;
  assign alu_op = op_lat;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = is_shift(op) ? SHIFT : EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      EXEC: state_nxt = IDLE;
      SHIFT: begin
        if (cnt == {SHAMT_W{1'b0}}) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Completion outputs, writeback value and flag/halt updates for the exit edge.
  always_comb begin
    done_nxt   = 1'b0;
    we_nxt     = 1'b0;
    result_nxt = result;
    szcv_nxt   = szcv;
    halted_nxt = halted;
    case (state)
      EXEC: begin
        done_nxt = 1'b1;
        case (op_lat)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            result_nxt = alu_out;
            szcv_nxt   = alu_szcv;
            we_nxt     = 1'b1;
          end
          OP_CMP:  szcv_nxt = alu_szcv;
          OP_MOV: begin
            result_nxt = b_lat;
            we_nxt     = 1'b1;
          end
          OP_HALT: halted_nxt = 1'b1;
          default: done_nxt = 1'b1;
        endcase
      end
      SHIFT: begin
        if (cnt == {SHAMT_W{1'b0}}) begin
          done_nxt   = 1'b1;
          we_nxt     = 1'b1;
          result_nxt = work;
          szcv_nxt   = {work[DATA_W-1], (work == {DATA_W{1'b0}}), cout, 1'b0};
        end else begin
          done_nxt = 1'b0;
        end
      end
      default: done_nxt = 1'b0;
    endcase
  end

  // Registered outputs and architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      we     <= 1'b0;
      result <= {DATA_W{1'b0}};
      szcv   <= 4'b0000;
      halted <= 1'b0;
    end else begin
      done   <= done_nxt;
      we     <= we_nxt;
      result <= result_nxt;
      szcv   <= szcv_nxt;
      halted <= halted_nxt;
    end
  end

  // Operand latches and the serial shifter working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_lat <= 4'b0000;
      a_lat  <= {DATA_W{1'b0}};
      b_lat  <= {DATA_W{1'b0}};
      work   <= {DATA_W{1'b0}};
      cnt    <= {SHAMT_W{1'b0}};
      cout   <= 1'b0;
    end else if (accept) begin
      op_lat <= op;
      a_lat  <= in_a;
      b_lat  <= in_b;
      work   <= in_a;
      cnt    <= in_b[SHAMT_W-1:0];
      cout   <= 1'b0;
    end else if (shift_run) begin
      work <= step[DATA_W-1:0];
      cnt  <= cnt - SHAMT_W'(1);
      cout <= step[DATA_W];
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed scoreboard bench for alu_seq_ctrl with a behavioural ALU attached.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        busy;
  logic        done;
  logic        we;
  logic [15:0] result;
  logic [3:0]  szcv;
  logic        halted;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_out;
  logic [3:0]  alu_szcv;

  alu_seq_ctrl #(.DATA_W(16), .SHAMT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
    .busy(busy), .done(done), .we(we), .result(result), .szcv(szcv),
    .halted(halted), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_szcv(alu_szcv)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: C is carry for ADD and borrow for SUB/CMP.
  logic [16:0] t;
  always_comb begin
    t        = 17'd0;
    alu_out  = 16'h0000;
    alu_szcv = 4'b0000;
    case (alu_op)
      4'b0000: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = t[15:0];
        alu_szcv = {t[15], t[15:0] == 16'h0000, t[16],
                    (alu_a[15] == alu_b[15]) && (t[15] != alu_a[15])};
      end
      4'b0001, 4'b0101: begin
        t = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out = t[15:0];
        alu_szcv = {t[15], t[15:0] == 16'h0000, t[16],
                    (alu_a[15] != alu_b[15]) && (t[15] != alu_a[15])};
      end
      4'b0010: begin alu_out = alu_a & alu_b; alu_szcv = {alu_out[15], alu_out == 16'h0000, 2'b00}; end
      4'b0011: begin alu_out = alu_a | alu_b; alu_szcv = {alu_out[15], alu_out == 16'h0000, 2'b00}; end
      4'b0100: begin alu_out = alu_a ^ alu_b; alu_szcv = {alu_out[15], alu_out == 16'h0000, 2'b00}; end
      default: alu_out = 16'h0000;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          dcyc;
    logic        we;
    logic [15:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pops one expectation and checks timing and writeback.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("done_with_no_pending_op", done, 1'b0);
      end else begin
        mon_e = q.pop_front();
        chk("done_cycle", cyc, mon_e.dcyc);
        chk("we", we, mon_e.we);
        chk("result", result, mon_e.res);
        chk("szcv", szcv, mon_e.flg);
        chk("busy_at_done", busy, 1'b0);
      end
    end
    if (!rst && we) chk("we_only_with_done", done, 1'b1);
  end

  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic w, input logic [15:0] r, input logic [3:0] f);
    exp_t e;
    @(negedge clk);
    op = o; in_a = a; in_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    e.dcyc = (o[3:2] == 2'b10) ? cyc + 1 + int'(b[3:0]) : cyc + 1;
    e.we   = w;
    e.res  = r;
    e.flg  = f;
    q.push_back(e);
    start = 1'b0;
    @(negedge clk);
    chk("alu_op_latched", alu_op, o);
    chk("alu_a_latched", alu_a, a);
    chk("alu_b_latched", alu_b, b);
    chk("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout_pending", q.size(), 0);
    @(negedge clk);
  endtask

  int   n0;
  exp_t e2;

  initial begin
    rst = 1'b1; start = 1'b0; op = 4'b0000; in_a = 16'h0000; in_b = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_szcv", szcv, 4'b0000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_alu_a", alu_a, 16'h0000);
    chk("rst_alu_op", alu_op, 4'b0000);
    rst = 1'b0;

    issue(4'b0000, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b1001); // ADD overflow
    wait_idle();
    issue(4'b0101, 16'h0005, 16'h0005, 1'b0, 16'h8000, 4'b0100); // CMP
    wait_idle();
    issue(4'b0110, 16'h0000, 16'h1234, 1'b1, 16'h1234, 4'b0100); // MOV
    wait_idle();
    issue(4'b1011, 16'h8001, 16'h0004, 1'b1, 16'hF800, 4'b1000); // SRA d=4
    wait_idle();
    issue(4'b1000, 16'h8001, 16'h0001, 1'b1, 16'h0002, 4'b0010); // SLL d=1
    wait_idle();
    issue(4'b1001, 16'h8001, 16'h0004, 1'b1, 16'h0018, 4'b0000); // SLR d=4
    wait_idle();
    issue(4'b1010, 16'h0001, 16'h0000, 1'b1, 16'h0001, 4'b0000); // SRL d=0
    wait_idle();
    issue(4'b0100, 16'hF0F0, 16'hFFFF, 1'b1, 16'h0F0F, 4'b0000); // XOR
    wait_idle();
    issue(4'b1100, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0F0F, 4'b0000); // IN no-op
    wait_idle();

    // Long shift with start held high; the ADD must be taken on the done cycle.
    issue(4'b1010, 16'hFFFF, 16'h000F, 1'b1, 16'h0001, 4'b0010);
    n0 = cyc;
    op = 4'b0000; in_a = 16'h0001; in_b = 16'h0002; start = 1'b1;
    while (cyc < n0 + 17) @(posedge clk);
    #1;
    e2.dcyc = n0 + 18; e2.we = 1'b1; e2.res = 16'h0003; e2.flg = 4'b0000;
    q.push_back(e2);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_alu_op", alu_op, 4'b0000);
    chk("b2b_alu_b", alu_b, 16'h0002);
    wait_idle();

    issue(4'b1111, 16'h0000, 16'h0000, 1'b0, 16'h0003, 4'b0000); // HALT
    wait_idle();
    chk("halted_set", halted, 1'b1);
    op = 4'b0000; in_a = 16'h0001; in_b = 16'h0001; start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("halted_ignores_start", busy, 1'b0);
    end
    start = 1'b0;
    chk("halted_result_held", result, 16'h0003);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_clears_halted", halted, 1'b0);
    rst = 1'b0;

    issue(4'b0001, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 4'b1010); // SUB with borrow
    wait_idle();

    // Reset three cycles into a d=15 shift aborts it.
    issue(4'b1000, 16'h1234, 16'h000F, 1'b1, 16'h0000, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 16'h0000);
    chk("abort_szcv", szcv, 4'b0000);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_stays_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
